// File: rtl/prog_loader_pkg.sv
// Shared types and sizing for the program loader: FSM state encoding and word widths.
package prog_loader_pkg;

   localparam int IMEM_DEPTH_DEF = 16;
   localparam int HALF_W         = 16;
   localparam int INST_W         = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_HI,
      ST_LOAD_LO,
      ST_WRITE,
      ST_CHECK,
      ST_RUN,
      ST_ERR
   } state_e;

endpackage

// File: rtl/prog_loader_cksum.sv
// 16-bit XOR accumulator over accepted program halfwords; exists only when
// PROG_LOADER_CKSUM_EN is defined.
`ifdef PROG_LOADER_CKSUM_EN
module prog_loader_cksum
   import prog_loader_pkg::*;
(
   input  logic              clk,
   input  logic              sys_rst,
   input  logic              clr,
   input  logic              en,
   input  logic [HALF_W-1:0] din,
   output logic [HALF_W-1:0] sum
);

   logic [HALF_W-1:0] sum_q;

   always_ff @(posedge clk) begin
      if (sys_rst || clr) begin
         sum_q <= '0;
      end else if (en) begin
         sum_q <= sum_q ^ din;
      end
   end

   assign sum = sum_q;

endmodule
`endif

// File: rtl/prog_loader.sv
// Assembles 16-bit halfwords into 32-bit instructions, writes them to imem and holds the
// core in reset until a well-formed program is loaded. PROG_LOADER_CKSUM_EN adds a checksum stage.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int IMEM_DEPTH = IMEM_DEPTH_DEF,
   parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
   input  logic              clk,
   input  logic              sys_rst,
   input  logic              start,
   input  logic [HALF_W-1:0] ld_data,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic              ld_last,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [INST_W-1:0] imem_wdata,
   output logic              core_rst,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   count
);

   localparam int               CNT_W    = ADDR_W + 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IMEM_DEPTH - 1);

   state_e            state_q, state_d;
   logic [HALF_W-1:0] hi_q, hi_d;
   logic [HALF_W-1:0] lo_q, lo_d;
   logic              last_q, last_d;
   logic [CNT_W-1:0]  count_q, count_d;

`ifdef PROG_LOADER_CKSUM_EN
   logic [HALF_W-1:0] sum;
   logic              cksum_clr;
   logic              cksum_en;

   assign cksum_clr = start && (state_q inside {ST_IDLE, ST_RUN, ST_ERR});
   assign cksum_en  = ld_valid && (state_q inside {ST_LOAD_HI, ST_LOAD_LO});

   prog_loader_cksum u_cksum (
      .clk     (clk),
      .sys_rst (sys_rst),
      .clr     (cksum_clr),
      .en      (cksum_en),
      .din     (ld_data),
      .sum     (sum)
   );
`endif

   // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
   always_comb begin
      state_d    = state_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      last_d     = last_q;
      count_d    = count_q;
      ld_ready   = 1'b0;
      imem_we    = 1'b0;
      imem_addr  = '0;
      imem_wdata = '0;
      core_rst   = 1'b1;
      busy       = 1'b0;
      done       = 1'b0;
      err        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               count_d = '0;
               state_d = ST_LOAD_HI;
            end
         end
         ST_LOAD_HI: begin
            ld_ready = 1'b1;
            busy     = 1'b1;
            if (ld_valid) begin
               hi_d    = ld_data;
               state_d = ld_last ? ST_ERR : ST_LOAD_LO;
            end
         end
         ST_LOAD_LO: begin
            ld_ready = 1'b1;
            busy     = 1'b1;
            if (ld_valid) begin
               lo_d    = ld_data;
               last_d  = ld_last;
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            busy       = 1'b1;
            imem_we    = 1'b1;
            imem_addr  = count_q[ADDR_W-1:0];
            imem_wdata = {hi_q, lo_q};
            count_d    = count_q + CNT_W'(1);
            // A last word wins over overflow: a full-depth program is still valid.
            if (last_q) begin
`ifdef PROG_LOADER_CKSUM_EN
               state_d = ST_CHECK;
`else
               state_d = ST_RUN;
`endif
            end else if (count_q == LAST_IDX) begin
               state_d = ST_ERR;
            end else begin
               state_d = ST_LOAD_HI;
            end
         end
`ifdef PROG_LOADER_CKSUM_EN
         ST_CHECK: begin
            ld_ready = 1'b1;
            busy     = 1'b1;
            if (ld_valid) begin
               state_d = (ld_data == sum) ? ST_RUN : ST_ERR;
            end
         end
`endif
         ST_RUN: begin
            core_rst = 1'b0;
            done     = 1'b1;
            if (start) begin
               count_d = '0;
               state_d = ST_LOAD_HI;
            end
         end
         ST_ERR: begin
            err = 1'b1;
            if (start) begin
               count_d = '0;
               state_d = ST_LOAD_HI;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign count = count_q;

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (sys_rst) begin
         state_q <= ST_IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         last_q  <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         last_q  <= last_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader against a halfword-stream reference model;
// exercises the checksum path when PROG_LOADER_CKSUM_EN is defined.
module tb_prog_loader;
   import prog_loader_pkg::*;

   localparam int DEPTH  = 16;
   localparam int AW     = 4;
   localparam int BUDGET = 60;

   typedef struct {
      logic [AW-1:0]     addr;
      logic [INST_W-1:0] data;
   } wr_t;

   logic              clk = 1'b0;
   logic              sys_rst;
   logic              start;
   logic [HALF_W-1:0] ld_data;
   logic              ld_valid;
   logic              ld_ready;
   logic              ld_last;
   logic              imem_we;
   logic [AW-1:0]     imem_addr;
   logic [INST_W-1:0] imem_wdata;
   logic              core_rst;
   logic              busy;
   logic              done;
   logic              err;
   logic [AW:0]       count;

   int                checks = 0;
   int                errors = 0;
   wr_t               exp_q[$];
   wr_t               mon_w;
   logic [INST_W-1:0] dut_mem [DEPTH];
   logic [INST_W-1:0] exp_mem [DEPTH];

   always #5 clk = ~clk;

   prog_loader dut (
      .clk        (clk),
      .sys_rst    (sys_rst),
      .start      (start),
      .ld_data    (ld_data),
      .ld_valid   (ld_valid),
      .ld_ready   (ld_ready),
      .ld_last    (ld_last),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_rst   (core_rst),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .count      (count)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Every write strobe must match the next expected write; core reset is the inverse of done.
   always @(negedge clk) begin
      if (!sys_rst) begin
         check("core_rst_vs_done", core_rst, !done);
         if (imem_we) begin
            if (exp_q.size() == 0) begin
               check("unexpected_write", imem_addr, {AW{1'b1}} ^ imem_addr);
            end else begin
               mon_w = exp_q.pop_front();
               check("wr_addr", imem_addr, mon_w.addr);
               check("wr_data", imem_wdata, mon_w.data);
            end
            dut_mem[imem_addr] = imem_wdata;
         end
      end
   end

   // Reference: walk the halfword stream pairwise and derive writes, outcome and count.
   task automatic model_prog(input logic [HALF_W-1:0] hw[$], input bit lst[$],
                             output int acc, output bit x_err, output int x_cnt);
      int                i;
      logic [HALF_W-1:0] hi;
      logic [HALF_W-1:0] lo;
      wr_t               w;
      acc = 0; x_err = 1'b0; x_cnt = 0; i = 0;
      while (1) begin
         if (i >= hw.size()) return;
         hi = hw[i]; acc++;
         if (lst[i]) begin x_err = 1'b1; return; end
         i++;
         if (i >= hw.size()) return;
         lo = hw[i]; acc++; i++;
         w.addr = AW'(x_cnt);
         w.data = {hi, lo};
         exp_q.push_back(w);
         exp_mem[x_cnt] = {hi, lo};
         x_cnt++;
         if (lst[i-1]) begin
`ifdef PROG_LOADER_CKSUM_EN
            begin
               logic [HALF_W-1:0] cs;
               cs = '0;
               for (int k = 0; k < i; k++) cs = cs ^ hw[k];
               if (i >= hw.size()) return;
               acc++;
               x_err = (hw[i] != cs);
            end
`endif
            return;
         end
         if (x_cnt == DEPTH) begin x_err = 1'b1; return; end
      end
   endtask

   task automatic drive_hw(input logic [HALF_W-1:0] d, input bit l, input int prob,
                           input bit poke, output bit ok);
      bit hit;
      ok = 1'b0;
      ld_data = d;
      ld_last = l;
      for (int n = 0; n < BUDGET && !ok; n++) begin
         ld_valid = ($urandom_range(0, 99) < prob);
         start    = poke && busy && ($urandom_range(0, 7) == 0);
         @(negedge clk);
         hit = ld_valid && ld_ready;
         @(posedge clk); #1;
         start = 1'b0;
         ok = hit;
      end
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   task automatic pulse_start(input string tag);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, "_ready_after_start"}, ld_ready, 1);
      check({tag, "_core_rst_after_start"}, core_rst, 1);
      check({tag, "_count_cleared"}, count, 0);
   endtask

   task automatic wait_outcome(input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while (!(done || err) && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_settled"}, done || err, 1);
   endtask

   task automatic check_image(input string tag);
      for (int a = 0; a < DEPTH; a++) check({tag, "_mem"}, dut_mem[a], exp_mem[a]);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_ld_ready"}, ld_ready, 0);
      check({tag, "_imem_we"}, imem_we, 0);
      check({tag, "_imem_addr"}, imem_addr, 0);
      check({tag, "_imem_wdata"}, imem_wdata, 0);
      check({tag, "_core_rst"}, core_rst, 1);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_err"}, err, 0);
      check({tag, "_count"}, count, 0);
   endtask

   task automatic run_prog(input string tag, input logic [HALF_W-1:0] hw[$], input bit lst[$],
                           input int prob, input bit poke);
      int acc_m, cnt_m, acc;
      bit err_m, ok;
      model_prog(hw, lst, acc_m, err_m, cnt_m);
      pulse_start(tag);
      acc = 0;
      foreach (hw[i]) begin
         drive_hw(hw[i], lst[i], prob, poke, ok);
         if (!ok) break;
         acc++;
      end
      check({tag, "_accepted"}, acc, acc_m);
      wait_outcome(tag);
      check({tag, "_err"}, err, err_m);
      check({tag, "_done"}, done, !err_m);
      check({tag, "_core_rst"}, core_rst, err_m);
      check({tag, "_count"}, count, cnt_m);
      check_image(tag);
   endtask

   task automatic gen_prog(output logic [HALF_W-1:0] hw[$], output bit lst[$]);
      int kind, nw;
      hw = {}; lst = {};
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
         nw = $urandom_range(1, DEPTH);
         for (int k = 0; k < 2*nw - 1; k++) begin
            hw.push_back(HALF_W'($urandom));
            lst.push_back(k == 2*nw - 2);
         end
      end else if (kind == 1) begin
         for (int k = 0; k < 2*(DEPTH + 1); k++) begin
            hw.push_back(HALF_W'($urandom));
            lst.push_back(1'b0);
         end
      end else begin
         nw = $urandom_range(1, DEPTH);
         for (int k = 0; k < 2*nw; k++) begin
            hw.push_back(HALF_W'($urandom));
            lst.push_back(k == 2*nw - 1);
         end
`ifdef PROG_LOADER_CKSUM_EN
         begin
            logic [HALF_W-1:0] cs;
            cs = '0;
            foreach (hw[k]) cs = cs ^ hw[k];
            if ($urandom_range(0, 3) == 0) cs = cs ^ HALF_W'($urandom_range(1, 65535));
            hw.push_back(cs);
            lst.push_back(1'b0);
         end
`endif
      end
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [HALF_W-1:0] hw[$];
      bit                lst[$];
      bit                ok;
      wr_t               w;

      for (int a = 0; a < DEPTH; a++) begin
         dut_mem[a] = '0;
         exp_mem[a] = '0;
      end
      sys_rst = 1'b1; start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
      repeat (3) @(posedge clk);
      #1;
      sys_rst = 1'b0;
      @(negedge clk);
      check_reset_vals("reset");

      // Directed program with hand-computed image and latency.
      @(posedge clk); #1;
      pulse_start("dir");
      w.addr = 4'd0; w.data = 32'h0840_0005; exp_q.push_back(w); exp_mem[0] = w.data;
      w.addr = 4'd1; w.data = 32'h1000_0003; exp_q.push_back(w); exp_mem[1] = w.data;
      drive_hw(16'h0840, 1'b0, 100, 1'b0, ok); check("dir_x0", ok, 1);
      drive_hw(16'h0005, 1'b0, 100, 1'b0, ok); check("dir_x1", ok, 1);
      drive_hw(16'h1000, 1'b0, 100, 1'b0, ok); check("dir_x2", ok, 1);
      drive_hw(16'h0003, 1'b1, 100, 1'b0, ok); check("dir_x3", ok, 1);
      @(negedge clk);
      check("dir_write_cycle_we", imem_we, 1);
      check("dir_write_cycle_done", done, 0);
`ifdef PROG_LOADER_CKSUM_EN
      drive_hw(16'h1846, 1'b0, 100, 1'b0, ok); check("dir_cksum_x", ok, 1);
`endif
      @(negedge clk);
      check("dir_done", done, 1);
      check("dir_core_rst", core_rst, 0);
      check("dir_count", count, 2);
      check_image("dir");

      // Restart from RUN, then an odd-length program.
      @(posedge clk); #1;
      pulse_start("odd");
      drive_hw(16'h1234, 1'b1, 100, 1'b0, ok); check("odd_x", ok, 1);
      wait_outcome("odd");
      check("odd_err", err, 1);
      check("odd_core_rst", core_rst, 1);
      check("odd_count", count, 0);

      // Overflow: 17 words without last.
      hw = {}; lst = {};
      for (int k = 0; k < 2*(DEPTH + 1); k++) begin
         hw.push_back(HALF_W'(16'h0101 * k + 16'h00A5));
         lst.push_back(1'b0);
      end
      @(posedge clk); #1;
      run_prog("ovf", hw, lst, 100, 1'b0);
      check("ovf_ready_low", ld_ready, 0);
      check("ovf_count16", count, 16);

      // Same program under backpressure and stray start pulses.
      gen_prog(hw, lst);
      hw = {}; lst = {};
      for (int k = 0; k < 12; k++) begin
         hw.push_back(HALF_W'($urandom));
         lst.push_back(k == 11);
      end
`ifdef PROG_LOADER_CKSUM_EN
      begin
         logic [HALF_W-1:0] cs;
         cs = '0;
         foreach (hw[k]) cs = cs ^ hw[k];
         hw.push_back(cs);
         lst.push_back(1'b0);
      end
`endif
      @(posedge clk); #1;
      run_prog("bp_fast", hw, lst, 100, 1'b0);
      @(posedge clk); #1;
      run_prog("bp_slow", hw, lst, 35, 1'b1);

      // sys_rst while waiting for the lo halfword.
      @(posedge clk); #1;
      pulse_start("rst");
      drive_hw(16'hBEEF, 1'b0, 100, 1'b0, ok); check("rst_hi_x", ok, 1);
      check("rst_in_lo_busy", busy, 1);
      sys_rst = 1'b1;
      @(posedge clk); #1;
      sys_rst = 1'b0;
      check_reset_vals("sysrst");
      @(negedge clk);
      check("sysrst_still_idle", ld_ready, 0);
      check_image("sysrst");

`ifdef PROG_LOADER_CKSUM_EN
      hw = '{16'hAAAA, 16'h5555, 16'hFFFF}; lst = '{1'b0, 1'b1, 1'b0};
      @(posedge clk); #1;
      run_prog("ck_good", hw, lst, 100, 1'b0);
      check("ck_good_done", done, 1);
      hw = '{16'hAAAA, 16'h5555, 16'h0000};
      @(posedge clk); #1;
      run_prog("ck_bad", hw, lst, 100, 1'b0);
      check("ck_bad_err", err, 1);
`endif

      for (int r = 0; r < 25; r++) begin
         gen_prog(hw, lst);
         @(posedge clk); #1;
         run_prog($sformatf("rnd%0d", r), hw, lst, $urandom_range(30, 100), 1'b1);
      end

      repeat (3) @(negedge clk);
      check("exp_q_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
